lion_gate_counter: RTL and testbench

- Parametrised successor to the single-gate lion counter.
- Two light-beam gates, A (outer) and B (inner), are synchronised and debounced. An 8-state direction FSM decodes the full crossing sequence: entry is A, AB, B, none; exit is B, AB, A, none.
- Maintains an occupancy count with a selectable wrap or saturate policy, plus full/empty status, event pulses and sticky fault flags.
- Sits between the uio_in gate pins and the 7-segment decoder, which consumes the count.

---
 rtl/lion_pkg.sv | 21 ++
 rtl/lion_gate_debounce.sv | 40 ++++
 rtl/lion_gate_counter.sv | 137 +++++++++++++
 tb/tb_lion_gate_counter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lion_pkg.sv
// rtl/lion_pkg.sv - shared types and gate encodings for the lion gate counter
package lion_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EA    = 3'd1,
        EAB   = 3'd2,
        EB    = 3'd3,
        XB    = 3'd4,
        XAB   = 3'd5,
        XA    = 3'd6,
        FAULT = 3'd7
    } lion_state_t;

    // ab = {gate A, gate B}, 1 = beam broken
    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_A    = 2'b10;
    localparam logic [1:0] AB_B    = 2'b01;
    localparam logic [1:0] AB_BOTH = 2'b11;

endpackage

// File: rtl/lion_gate_debounce.sv
// rtl/lion_gate_debounce.sv - two-flop synchroniser plus stability-count debouncer
module lion_gate_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync_1;
    logic       sync_2;
    logic [7:0] stable_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            db         <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            // stable_cnt holds the number of earlier consecutive disagreeing cycles
            if (sync_2 != db) begin
                if (stable_cnt == LAST) begin
                    db         <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 8'd1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lion_gate_counter.sv
// rtl/lion_gate_counter.sv - two-gate direction FSM with occupancy counter and flags
module lion_gate_counter
    import lion_pkg::*;
#(
    parameter int CNT_W           = 4,
    parameter int MAX_COUNT       = 15,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WRAP_MODE       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gate_a_raw,
    input  logic             gate_b_raw,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             enter_pulse,
    output logic             exit_pulse,
    output logic             seq_err,
    output logic             ovf,
    output logic             unf
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    logic        a_db;
    logic        b_db;
    logic [1:0]  ab;
    lion_state_t state;
    lion_state_t state_nxt;
    logic        entry_evt;
    logic        exit_evt;
    logic        err_evt;

    lion_gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (gate_a_raw),
        .db    (a_db)
    );

    lion_gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (gate_b_raw),
        .db    (b_db)
    );

    assign ab = {a_db, b_db};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        entry_evt = 1'b0;
        exit_evt  = 1'b0;
        err_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (ab == AB_A)         state_nxt = EA;
                else if (ab == AB_B)    state_nxt = XB;
                else if (ab == AB_BOTH) begin state_nxt = FAULT; err_evt = 1'b1; end
            end
            EA: begin
                if (ab == AB_NONE)      state_nxt = IDLE;
                else if (ab == AB_BOTH) state_nxt = EAB;
                else if (ab == AB_B)    begin state_nxt = FAULT; err_evt = 1'b1; end
            end
            EAB: begin
                if (ab == AB_A)         state_nxt = EA;
                else if (ab == AB_B)    state_nxt = EB;
                else if (ab == AB_NONE) begin state_nxt = FAULT; err_evt = 1'b1; end
            end
            EB: begin
                if (ab == AB_NONE)      begin state_nxt = IDLE; entry_evt = 1'b1; end
                else if (ab == AB_BOTH) state_nxt = EAB;
                else if (ab == AB_A)    begin state_nxt = FAULT; err_evt = 1'b1; end
            end
            XB: begin
                if (ab == AB_NONE)      state_nxt = IDLE;
                else if (ab == AB_BOTH) state_nxt = XAB;
                else if (ab == AB_A)    begin state_nxt = FAULT; err_evt = 1'b1; end
            end
            XAB: begin
                if (ab == AB_B)         state_nxt = XB;
                else if (ab == AB_A)    state_nxt = XA;
                else if (ab == AB_NONE) begin state_nxt = FAULT; err_evt = 1'b1; end
            end
            XA: begin
                if (ab == AB_NONE)      begin state_nxt = IDLE; exit_evt = 1'b1; end
                else if (ab == AB_BOTH) state_nxt = XAB;
                else if (ab == AB_B)    begin state_nxt = FAULT; err_evt = 1'b1; end
            end
            FAULT: begin
                if (ab == AB_NONE)      state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            enter_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            seq_err     <= 1'b0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
        end else begin
            enter_pulse <= entry_evt;
            exit_pulse  <= exit_evt;
            seq_err     <= err_evt;
            // clear wins over a coincident event; the event's pulse still goes out
            if (clear) begin
                count <= '0;
                ovf   <= 1'b0;
                unf   <= 1'b0;
            end else if (entry_evt) begin
                if (count < MAX_C)       count <= count + 1'b1;
                else if (WRAP_MODE != 0) count <= '0;
                else                     ovf   <= 1'b1;
            end else if (exit_evt) begin
                if (count != '0)         count <= count - 1'b1;
                else if (WRAP_MODE != 0) count <= MAX_C;
                else                     unf   <= 1'b1;
            end
        end
    end

    assign full  = (count == MAX_C);
    assign empty = (count == '0);

endmodule

// File: tb/tb_lion_gate_counter.sv
// tb/tb_lion_gate_counter.sv - directed and random checks of wrap and saturate counters
module tb_lion_gate_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gate_a_raw = 1'b0;
    logic       gate_b_raw = 1'b0;
    logic       clear = 1'b0;

    logic [3:0] count_w, count_s;
    logic       full_w, empty_w, enter_w, exit_w, err_w, ovf_w, unf_w;
    logic       full_s, empty_s, enter_s, exit_s, err_s, ovf_s, unf_s;

    int errors = 0;
    int checks = 0;

    int m_cw = 0, m_cs = 0;
    int m_ovf = 0, m_unf = 0;
    int m_dir = 0, m_pos = 0;
    int exp_enter = 0, exp_exit = 0, exp_err = 0;
    int n_enter_w = 0, n_exit_w = 0, n_err_w = 0;
    int n_enter_s = 0, n_exit_s = 0, n_err_s = 0;

    logic [1:0] path_e [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] path_x [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

    always #5 clk = ~clk;

    lion_gate_counter #(.CNT_W(4), .MAX_COUNT(15), .DEBOUNCE_CYCLES(4), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .gate_a_raw(gate_a_raw), .gate_b_raw(gate_b_raw), .clear(clear),
        .count(count_w), .full(full_w), .empty(empty_w), .enter_pulse(enter_w), .exit_pulse(exit_w),
        .seq_err(err_w), .ovf(ovf_w), .unf(unf_w)
    );

    lion_gate_counter #(.CNT_W(4), .MAX_COUNT(15), .DEBOUNCE_CYCLES(4), .WRAP_MODE(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .gate_a_raw(gate_a_raw), .gate_b_raw(gate_b_raw), .clear(clear),
        .count(count_s), .full(full_s), .empty(empty_s), .enter_pulse(enter_s), .exit_pulse(exit_s),
        .seq_err(err_s), .ovf(ovf_s), .unf(unf_s)
    );

    // cycles high are counted, so a stretched pulse shows up as an extra event
    always @(negedge clk) begin
        if (enter_w === 1'b1) n_enter_w++;
        if (exit_w  === 1'b1) n_exit_w++;
        if (err_w   === 1'b1) n_err_w++;
        if (enter_s === 1'b1) n_enter_s++;
        if (exit_s  === 1'b1) n_exit_s++;
        if (err_s   === 1'b1) n_err_s++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] path_at(input int dir, input int idx);
        return (dir == 1) ? path_e[idx] : path_x[idx];
    endfunction

    // crossing model: position along the entry or exit path of gate levels
    task automatic model_step(input logic [1:0] ab);
        if (m_dir == 0) begin
            if (ab == path_e[1])      begin m_dir = 1; m_pos = 1; end
            else if (ab == path_x[1]) begin m_dir = 2; m_pos = 1; end
            else if (ab == 2'b11)     begin m_dir = 3; exp_err++; end
        end else if (m_dir == 3) begin
            if (ab == 2'b00) m_dir = 0;
        end else if (ab == path_at(m_dir, m_pos)) begin
        end else if (ab == path_at(m_dir, m_pos - 1)) begin
            m_pos--;
            if (m_pos == 0) m_dir = 0;
        end else if (ab == path_at(m_dir, m_pos + 1)) begin
            m_pos++;
            if (m_pos == 4) begin
                if (m_dir == 1) begin
                    exp_enter++;
                    m_cw = (m_cw == 15) ? 0 : m_cw + 1;
                    if (m_cs == 15) m_ovf = 1; else m_cs++;
                end else begin
                    exp_exit++;
                    m_cw = (m_cw == 0) ? 15 : m_cw - 1;
                    if (m_cs == 0) m_unf = 1; else m_cs--;
                end
                m_dir = 0;
            end
        end else begin
            m_dir = 3;
            exp_err++;
        end
    endtask

    task automatic set_ab(input logic [1:0] ab, input int hold);
        @(posedge clk); #1;
        gate_a_raw = ab[1];
        gate_b_raw = ab[0];
        model_step(ab);
        repeat (hold) @(posedge clk);
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        chk({tag, ".count_w"}, 32'(count_w), 32'(m_cw));
        chk({tag, ".count_s"}, 32'(count_s), 32'(m_cs));
        chk({tag, ".full_w"},  32'(full_w),  32'(m_cw == 15));
        chk({tag, ".empty_w"}, 32'(empty_w), 32'(m_cw == 0));
        chk({tag, ".full_s"},  32'(full_s),  32'(m_cs == 15));
        chk({tag, ".empty_s"}, 32'(empty_s), 32'(m_cs == 0));
        chk({tag, ".ovf_s"},   32'(ovf_s),   32'(m_ovf));
        chk({tag, ".unf_s"},   32'(unf_s),   32'(m_unf));
        chk({tag, ".ovf_w"},   32'(ovf_w),   32'd0);
        chk({tag, ".unf_w"},   32'(unf_w),   32'd0);
        chk({tag, ".enter_w"}, 32'(n_enter_w), 32'(exp_enter));
        chk({tag, ".exit_w"},  32'(n_exit_w),  32'(exp_exit));
        chk({tag, ".err_w"},   32'(n_err_w),   32'(exp_err));
        chk({tag, ".enter_s"}, 32'(n_enter_s), 32'(exp_enter));
        chk({tag, ".exit_s"},  32'(n_exit_s),  32'(exp_exit));
        chk({tag, ".err_s"},   32'(n_err_s),   32'(exp_err));
    endtask

    task automatic entry();
        set_ab(2'b10, 10); set_ab(2'b11, 10); set_ab(2'b01, 10); set_ab(2'b00, 10);
    endtask

    task automatic leave();
        set_ab(2'b01, 10); set_ab(2'b11, 10); set_ab(2'b10, 10); set_ab(2'b00, 10);
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_cw = 0; m_cs = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".count_w"}, 32'(count_w), 32'd0);
        chk({tag, ".count_s"}, 32'(count_s), 32'd0);
        chk({tag, ".empty_w"}, 32'(empty_w), 32'd1);
        chk({tag, ".full_w"},  32'(full_w),  32'd0);
        chk({tag, ".pulses"},  32'({enter_w, exit_w, err_w, enter_s, exit_s, err_s}), 32'd0);
        chk({tag, ".flags"},   32'({ovf_w, unf_w, ovf_s, unf_s}), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check_all("idle");

        entry();
        check_all("entry1");

        @(posedge clk); #1;
        gate_a_raw = 1'b1;
        repeat (2) @(posedge clk); #1;
        gate_a_raw = 1'b0;
        repeat (12) @(posedge clk);
        check_all("glitch");

        leave();
        check_all("exit1");

        set_ab(2'b10, 10); set_ab(2'b00, 10);
        check_all("abort");
        set_ab(2'b10, 10); set_ab(2'b11, 10); set_ab(2'b10, 10); set_ab(2'b00, 10);
        check_all("backout");

        set_ab(2'b11, 10);
        check_all("illegal");
        set_ab(2'b01, 10);
        set_ab(2'b00, 10);
        check_all("fault_exit");
        entry();
        check_all("after_fault");

        do_clear();
        for (int i = 0; i < 15; i++) entry();
        check_all("fill15");
        entry();
        check_all("entry16");
        do_clear();
        check_all("clear");
        leave();
        check_all("exit_at_0");

        for (int i = 0; i < 60; i++) begin
            set_ab(2'($urandom_range(0, 3)), 8 + int'($urandom_range(0, 6)));
            check_all($sformatf("rand%0d", i));
        end
        set_ab(2'b00, 10);
        entry();
        check_all("rand_end");

        set_ab(2'b10, 10); set_ab(2'b11, 10);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        gate_a_raw = 1'b0;
        gate_b_raw = 1'b0;
        m_cw = 0; m_cs = 0; m_ovf = 0; m_unf = 0; m_dir = 0; m_pos = 0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check_all("post_rst");
        entry();
        check_all("post_rst_entry");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
